// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: counts synchronised reference rising edges per core-clock window,
// qualifies lock and releases the downstream reset. PLL_LOCK_MON_STICKY_ERR_EN makes err_o sticky.
module pll_lock_monitor #(
  parameter int WINDOW     = 1024,
  parameter int EXP_EDGES  = 256,
  parameter int TOL        = 2,
  parameter int GOOD_COUNT = 4,
  parameter int RST_HOLD   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ref_clk_i,
  output logic        locked_o,
  output logic        sys_rst_n_o,
  output logic        err_o,
  output logic [15:0] edge_count_o,
  output logic        meas_valid_o
);

  localparam int WW  = $clog2(WINDOW);
  localparam int GCW = $clog2(GOOD_COUNT + 1);
  localparam int HCW = $clog2(RST_HOLD + 1);
  localparam logic [WW-1:0]      WLAST  = WW'(WINDOW - 1);
  localparam logic [GCW-1:0]     GLAST  = GCW'(GOOD_COUNT - 1);
  localparam logic [HCW-1:0]     HLAST  = HCW'(RST_HOLD - 1);
  localparam logic signed [16:0] EXP_S  = 17'(EXP_EDGES);
  localparam logic signed [16:0] TOL_S  = 17'(TOL);

  typedef enum logic [1:0] {ACQUIRE, HOLD, LOCKED} state_e;

  state_e             state_q, state_d;
  logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [15:0]        ecnt_q, ecnt_d, ecnt_fin;
  logic [15:0]        edge_count_q, edge_count_d;
  logic               meas_valid_q, meas_valid_d;
  logic [GCW-1:0]     gcnt_q, gcnt_d;
  logic [HCW-1:0]     hcnt_q, hcnt_d;
  logic               locked_q, locked_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               err_q, err_d;
  logic               rise, close, good, loss;
  logic signed [16:0] diff;

  // Measurement datapath; an edge seen in the closing cycle still belongs to that window.
  always_comb begin
    s1_d         = ref_clk_i;
    s2_d         = s1_q;
    s3_d         = s2_q;
    rise         = s2_q & ~s3_q;
    close        = (wcnt_q == WLAST);
    wcnt_d       = wcnt_q + 1'b1;
    ecnt_fin     = (rise && (ecnt_q != '1)) ? ecnt_q + 16'd1 : ecnt_q;
    diff         = signed'({1'b0, ecnt_fin}) - EXP_S;
    good         = (diff <= TOL_S) && (diff >= -TOL_S);
    ecnt_d       = close ? '0 : ecnt_fin;
    edge_count_d = close ? ecnt_fin : edge_count_q;
    meas_valid_d = close;
  end

  // Bad-window check comes first in HOLD so it beats a coincident hold expiry.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    hcnt_d  = hcnt_q;
    loss    = 1'b0;
    case (state_q)
      ACQUIRE: begin
        if (close) begin
          if (!good) begin
            gcnt_d = '0;
          end else if (gcnt_q == GLAST) begin
            gcnt_d  = '0;
            hcnt_d  = '0;
            state_d = HOLD;
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (close && !good) begin
          gcnt_d  = '0;
          hcnt_d  = '0;
          state_d = ACQUIRE;
        end else if (hcnt_q == HLAST) begin
          hcnt_d  = '0;
          state_d = LOCKED;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (close && !good) begin
          gcnt_d  = '0;
          loss    = 1'b1;
          state_d = ACQUIRE;
        end
      end
      default: begin
        gcnt_d  = '0;
        hcnt_d  = '0;
        state_d = ACQUIRE;
      end
    endcase
    locked_d    = (state_d == LOCKED);
    sys_rst_n_d = (state_d == LOCKED);
`ifdef PLL_LOCK_MON_STICKY_ERR_EN
    err_d = err_q | loss;
`else
    err_d = loss;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACQUIRE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      wcnt_q       <= '0;
      ecnt_q       <= '0;
      edge_count_q <= '0;
      meas_valid_q <= 1'b0;
      gcnt_q       <= '0;
      hcnt_q       <= '0;
      locked_q     <= 1'b0;
      sys_rst_n_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      wcnt_q       <= wcnt_d;
      ecnt_q       <= ecnt_d;
      edge_count_q <= edge_count_d;
      meas_valid_q <= meas_valid_d;
      gcnt_q       <= gcnt_d;
      hcnt_q       <= hcnt_d;
      locked_q     <= locked_d;
      sys_rst_n_q  <= sys_rst_n_d;
      err_q        <= err_d;
    end
  end

  assign locked_o     = locked_q;
  assign sys_rst_n_o  = sys_rst_n_q;
  assign err_o        = err_q;
  assign edge_count_o = edge_count_q;
  assign meas_valid_o = meas_valid_q;

endmodule
